// File: rtl/input_buffer_first.sv
// input_buffer_first: FWFT synchronous FIFO for router ingress; optional sticky ovf via INPUT_BUFFER_FIRST_OVF_EN
module input_buffer_first #(
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_WIDTH = 4,
  parameter int DATA_WIDTH = 70
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  rok,
  output logic                  ack
`ifdef INPUT_BUFFER_FIRST_OVF_EN
  ,
  output logic                  ovf
`endif
);
  localparam logic [FIFO_WIDTH:0]   depth_c = FIFO_DEPTH[FIFO_WIDTH:0];
  localparam logic [FIFO_WIDTH:0]   cnt_one = 1;
  localparam logic [FIFO_WIDTH-1:0] ptr_one = 1;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [FIFO_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [FIFO_WIDTH:0]   count;
  logic                  do_wr, do_rd;
  // Status flags, accepted-operation strobes and the fall-through head word
  always_comb begin
    rok   = count != '0;
    ack   = count != depth_c;
    do_rd = rd_en & rok;
    do_wr = wr_en & (ack | do_rd);
    dout  = rok ? mem[rd_ptr] : '0;
  end
  // Storage array; contents survive reset and are masked by rok
  always_ff @(posedge clk)
    if (rst && do_wr) mem[wr_ptr] <= din;
  // Pointers and occupancy; active-low synchronous reset discards queued data
  always_ff @(posedge clk)
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= do_wr ? wr_ptr + ptr_one : wr_ptr;
      rd_ptr <= do_rd ? rd_ptr + ptr_one : rd_ptr;
      count  <= (do_wr & ~do_rd) ? count + cnt_one : (~do_wr & do_rd) ? count - cnt_one : count;
    end
`ifdef INPUT_BUFFER_FIRST_OVF_EN
  // Sticky flag for a write dropped because the FIFO was full with no pop
  always_ff @(posedge clk)
    if (!rst) ovf <= 1'b0;
    else if (wr_en && !ack && !do_rd) ovf <= 1'b1;
`endif
endmodule

// File: tb/tb_input_buffer_first.sv
// tb_input_buffer_first: table, directed and randomized checks of input_buffer_first against a queue model
module tb_input_buffer_first;
  localparam int DW = 70;
  localparam int DEPTH = 16;
  logic clk = 0;
  logic rst = 0;
  logic [DW-1:0] din = '0;
  logic wr_en = 0, rd_en = 0;
  logic [DW-1:0] dout;
  logic rok, ack;
`ifdef INPUT_BUFFER_FIRST_OVF_EN
  logic ovf;
`endif
  int vectors = 0;
  int miscompares = 0;
  logic [DW-1:0] q[$];
  bit m_ovf = 0;

  input_buffer_first #(.FIFO_DEPTH(16), .FIFO_WIDTH(4), .DATA_WIDTH(70)) dut (
    .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .rd_en(rd_en),
    .dout(dout), .rok(rok), .ack(ack)
`ifdef INPUT_BUFFER_FIRST_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            rst_n;
    bit            wr;
    bit            rd;
    logic [DW-1:0] din;
    logic [DW-1:0] exp_dout;
    bit            exp_rok;
    bit            exp_ack;
  } vec_t;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit w, input bit rd, input logic [DW-1:0] d);
    bit pop, push;
    if (!r) begin
      q.delete();
      m_ovf = 0;
    end else begin
      pop  = rd && q.size() > 0;
      push = w && (q.size() < DEPTH || pop);
      if (w && q.size() == DEPTH && !pop) m_ovf = 1;
      if (pop) void'(q.pop_front());
      if (push) q.push_back(d);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_dout"}, dout, q.size() != 0 ? q[0] : '0);
    check({tag, "_rok"}, {69'b0, rok}, {69'b0, q.size() != 0});
    check({tag, "_ack"}, {69'b0, ack}, {69'b0, q.size() != DEPTH});
`ifdef INPUT_BUFFER_FIRST_OVF_EN
    check({tag, "_ovf"}, {69'b0, ovf}, {69'b0, m_ovf});
`endif
  endtask

  task automatic step(input bit r, input bit w, input bit rd, input logic [DW-1:0] d);
    rst = r; wr_en = w; rd_en = rd; din = d;
    @(posedge clk);
    model_step(r, w, rd, d);
    #1;
  endtask

  vec_t tbl[10];

  initial begin
    tbl[0] = '{0, 0, 0, 70'h0,      70'h0,      0, 1};
    tbl[1] = '{0, 1, 1, 70'hAA,     70'h0,      0, 1};
    tbl[2] = '{1, 0, 0, 70'h0,      70'h0,      0, 1};
    tbl[3] = '{1, 1, 0, 70'h1_2345, 70'h1_2345, 1, 1};
    tbl[4] = '{1, 0, 1, 70'h0,      70'h0,      0, 1};
    tbl[5] = '{1, 0, 1, 70'h0,      70'h0,      0, 1};
    tbl[6] = '{1, 1, 1, 70'h5,      70'h5,      1, 1};
    tbl[7] = '{1, 1, 0, 70'h6,      70'h5,      1, 1};
    tbl[8] = '{1, 0, 1, 70'h0,      70'h6,      1, 1};
    tbl[9] = '{1, 0, 1, 70'h0,      70'h0,      0, 1};
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].rst_n, tbl[i].wr, tbl[i].rd, tbl[i].din);
      check($sformatf("tbl%0d_dout", i), dout, tbl[i].exp_dout);
      check($sformatf("tbl%0d_rok", i), {69'b0, rok}, {69'b0, tbl[i].exp_rok});
      check($sformatf("tbl%0d_ack", i), {69'b0, ack}, {69'b0, tbl[i].exp_ack});
    end
    // fill 0..15
    for (int i = 0; i < DEPTH; i++) step(1, 1, 0, DW'(i));
    check("fill_ack", {69'b0, ack}, 70'h0);
    check("fill_head", dout, 70'h0);
    step(1, 1, 0, 70'd99);
    check("drop_ack", {69'b0, ack}, 70'h0);
    check("drop_head", dout, 70'h0);
`ifdef INPUT_BUFFER_FIRST_OVF_EN
    check("drop_ovf", {69'b0, ovf}, 70'h1);
`endif
    // full with simultaneous write/read
    step(1, 1, 1, 70'd77);
    check("fullrw_ack", {69'b0, ack}, 70'h0);
    check("fullrw_head", dout, 70'h1);
    for (int i = 1; i <= DEPTH; i++) begin
      check($sformatf("drain%0d", i), dout, i == DEPTH ? 70'd77 : DW'(i));
      step(1, 0, 1, 70'h0);
    end
    check("drained_rok", {69'b0, rok}, 70'h0);
    check("drained_ack", {69'b0, ack}, 70'h1);
    check("drained_dout", dout, 70'h0);
    // streaming wrap
    step(1, 1, 0, 70'd100);
    for (int i = 0; i < 40; i++) begin
      step(1, 1, 1, DW'(101 + i));
      check($sformatf("stream%0d", i), dout, DW'(101 + i));
    end
    step(1, 0, 1, 70'h0);
    step(1, 0, 1, 70'h0);
    check_model("rd_empty");
    // mid-operation reset
    for (int i = 0; i < 5; i++) step(1, 1, 0, DW'(200 + i));
    step(0, 1, 1, 70'h7);
    check("midrst_rok", {69'b0, rok}, 70'h0);
    check("midrst_ack", {69'b0, ack}, 70'h1);
    check("midrst_dout", dout, 70'h0);
`ifdef INPUT_BUFFER_FIRST_OVF_EN
    check("midrst_ovf", {69'b0, ovf}, 70'h0);
`endif
    step(1, 1, 0, 70'h3C);
    check("post_rst_dout", dout, 70'h3C);
    // randomized phases against the queue model
    for (int i = 0; i < 600; i++) begin
      int wp;
      wp = (i / 100) % 2 ? 30 : 70;
      step($urandom_range(99) != 0, $urandom_range(99) < wp, $urandom_range(99) >= wp,
           {$urandom, $urandom, $urandom});
      check_model($sformatf("rand%0d", i));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
